// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle RV32I core (addi, slli, lw, sw, beq, bne, jal, jalr).
// Outputs are decoded from the current state plus same-cycle mem_ready/Zero and forced low in reset.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUctrl,
  output logic [2:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECI    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t state_q, state_d;

  logic is_lw, is_sw, is_imm, is_br, is_jal, is_jalr;

  always_comb begin
    is_lw   = (op == OP_LOAD)   && (funct3 == 3'b010);
    is_sw   = (op == OP_STORE)  && (funct3 == 3'b010);
    is_imm  = (op == OP_IMM)    && ((funct3 == 3'b000) || (funct3 == 3'b001));
    is_br   = (op == OP_BRANCH) && ((funct3 == 3'b000) || (funct3 == 3'b001));
    is_jal  = (op == OP_JAL);
    is_jalr = (op == OP_JALR)   && (funct3 == 3'b000);
  end

  always_comb begin
    state_d   = state_q;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUctrl   = 3'b000;
    ImmSrc    = 3'b000;
    ResultSrc = 2'b00;
    retire    = 1'b0;
    illegal   = 1'b0;
    state_o   = state_q;

    case (state_q)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut <= OldPC + imm: the branch/jal target, computed speculatively.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 3'b100 : 3'b010;
        if (is_lw || is_sw)  state_d = S_MEMADR;
        else if (is_imm)     state_d = S_EXECI;
        else if (is_br)      state_d = S_BRANCH;
        else if (is_jal)     state_d = S_JAL;
        else if (is_jalr)    state_d = S_JALR;
        else                 state_d = S_TRAP;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUctrl = (funct3 == 3'b001) ? 3'b110 : 3'b000;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUctrl = 3'b001;
        retire  = 1'b1;
        PCWrite = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms the link OldPC+4.
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JAL;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase

    if (!rst_n) begin
      state_d   = S_FETCH;
      MemReq    = 1'b0;
      MemWrite  = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUctrl   = 3'b000;
      ImmSrc    = 3'b000;
      ResultSrc = 2'b00;
      retire    = 1'b0;
      illegal   = 1'b0;
      state_o   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through its state sequence.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero;
  logic       mem_ready;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUctrl, ImmSrc;
  logic       retire, illegal;
  logic [3:0] state_o;
  logic [19:0] outs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign outs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
                 ALUctrl, ImmSrc, ResultSrc, retire, illegal};

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .Zero(Zero), .mem_ready(mem_ready),
    .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .retire(retire),
    .illegal(illegal), .state_o(state_o)
  );

  // Drive mem_ready for the coming cycle at the falling edge, then let outputs settle.
  task automatic tick(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; op = 7'b0010011; funct3 = 3'b000; Zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      total++;
      if ({outs, state_o} !== 24'd0) begin
        bad++; $display("FAIL reset_outs cyc%0d: got %h want 000000", i, {outs, state_o});
      end
    end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
    total++;
    if ({state_o, MemReq} !== {4'd0, 1'b1}) begin
      bad++; $display("FAIL reset_release: state=%0d MemReq=%b want state=0 MemReq=1", state_o, MemReq);
    end
  endtask

  task automatic test_addi;
    logic [3:0] st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic       rd [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int rc = 0;
    op = 7'b0010011; funct3 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick(rd[i]);
      rc += int'(retire);
      total++;
      if (state_o !== st[i]) begin
        bad++; $display("FAIL addi_state cyc%0d: got %0d want %0d", i, state_o, st[i]);
      end
      if (i == 0) begin
        total++;
        if ({IRWrite, PCWrite, ALUSrcB, ResultSrc} !== 6'b11_10_10) begin
          bad++; $display("FAIL addi_fetch: got %b want 111010", {IRWrite, PCWrite, ALUSrcB, ResultSrc});
        end
      end
      if (i == 2) begin
        total++;
        if ({ALUSrcA, ALUSrcB, ALUctrl, ImmSrc} !== 10'b10_01_000_000) begin
          bad++; $display("FAIL addi_exec: got %b want 1001000000", {ALUSrcA, ALUSrcB, ALUctrl, ImmSrc});
        end
      end
      if (i == 3) begin
        total++;
        if ({RegWrite, ResultSrc} !== 3'b1_00) begin
          bad++; $display("FAIL addi_wb: got %b want 100", {RegWrite, ResultSrc});
        end
      end
    end
    total++;
    if (rc !== 1) begin bad++; $display("FAIL addi_retire_count: got %0d want 1", rc); end
  endtask

  task automatic test_slli;
    op = 7'b0010011; funct3 = 3'b001;
    tick(1'b1); tick(1'b0); tick(1'b0);
    total++;
    if ({state_o, ALUctrl} !== {4'd6, 3'b110}) begin
      bad++; $display("FAIL slli_exec: got state=%0d alu=%b want state=6 alu=110", state_o, ALUctrl);
    end
    tick(1'b0);
  endtask

  task automatic test_lw_wait;
    logic [3:0] st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       rd [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int rc = 0;
    op = 7'b0000011; funct3 = 3'b010;
    for (int i = 0; i < 8; i++) begin
      tick(rd[i]);
      rc += int'(retire);
      total++;
      if (state_o !== st[i]) begin
        bad++; $display("FAIL lw_state cyc%0d: got %0d want %0d", i, state_o, st[i]);
      end
      if (i == 2) begin
        total++;
        if ({ImmSrc, ALUSrcA, ALUSrcB} !== 7'b000_10_01) begin
          bad++; $display("FAIL lw_memadr: got %b want 0001001", {ImmSrc, ALUSrcA, ALUSrcB});
        end
      end
      if (i >= 3 && i <= 5) begin
        total++;
        if ({MemReq, AdrSrc, MemWrite, RegWrite} !== 4'b1100) begin
          bad++; $display("FAIL lw_memread cyc%0d: got %b want 1100", i, {MemReq, AdrSrc, MemWrite, RegWrite});
        end
      end
      if (i == 6) begin
        total++;
        if ({ResultSrc, RegWrite, MemReq} !== 4'b01_1_0) begin
          bad++; $display("FAIL lw_memwb: got %b want 0110", {ResultSrc, RegWrite, MemReq});
        end
      end
    end
    total++;
    if (rc !== 1) begin bad++; $display("FAIL lw_retire_count: got %0d want 1", rc); end
  endtask

  task automatic test_branch;
    op = 7'b1100011; Zero = 1'b1;
    for (int b = 0; b < 2; b++) begin
      funct3 = (b == 0) ? 3'b000 : 3'b001;
      tick(1'b1);
      total++;
      if (state_o !== 4'd0) begin bad++; $display("FAIL br%0d_fetch_state: got %0d want 0", b, state_o); end
      tick(1'b0);
      total++;
      if ({state_o, ImmSrc} !== {4'd1, 3'b010}) begin
        bad++; $display("FAIL br%0d_decode: got state=%0d imm=%b want state=1 imm=010", b, state_o, ImmSrc);
      end
      tick(1'b1);
      total++;
      if ({state_o, PCWrite, retire, ALUctrl, ALUSrcA, ALUSrcB} !==
          {4'd8, (b == 0), 1'b1, 3'b001, 2'b10, 2'b00}) begin
        bad++; $display("FAIL br%0d_branch: got %b want %b", b,
          {state_o, PCWrite, retire, ALUctrl, ALUSrcA, ALUSrcB}, {4'd8, (b == 0), 1'b1, 3'b001, 2'b10, 2'b00});
      end
    end
    Zero = 1'b0;
    tick(1'b0);
    total++;
    if (state_o !== 4'd0) begin bad++; $display("FAIL br_return: got %0d want 0", state_o); end
  endtask

  task automatic test_jalr;
    logic [3:0] st [6] = '{4'd0, 4'd1, 4'd10, 4'd9, 4'd7, 4'd0};
    logic       rd [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    op = 7'b1100111; funct3 = 3'b000;
    for (int i = 0; i < 6; i++) begin
      tick(rd[i]);
      total++;
      if (state_o !== st[i]) begin
        bad++; $display("FAIL jalr_state cyc%0d: got %0d want %0d", i, state_o, st[i]);
      end
      if (i == 2) begin
        total++;
        if ({ALUSrcA, ALUSrcB, ImmSrc, PCWrite} !== 8'b10_01_000_0) begin
          bad++; $display("FAIL jalr_addr: got %b want 10010000", {ALUSrcA, ALUSrcB, ImmSrc, PCWrite});
        end
      end
      if (i == 3) begin
        total++;
        if ({PCWrite, ALUSrcA, ALUSrcB, ResultSrc, RegWrite} !== 8'b1_01_10_00_0) begin
          bad++; $display("FAIL jalr_jal: got %b want 10110000", {PCWrite, ALUSrcA, ALUSrcB, ResultSrc, RegWrite});
        end
      end
      if (i == 4) begin
        total++;
        if ({RegWrite, retire, PCWrite} !== 3'b110) begin
          bad++; $display("FAIL jalr_wb: got %b want 110", {RegWrite, retire, PCWrite});
        end
      end
    end
  endtask

  task automatic test_jal;
    op = 7'b1101111; funct3 = 3'b101;
    tick(1'b1);
    tick(1'b0);
    total++;
    if ({state_o, ImmSrc} !== {4'd1, 3'b100}) begin
      bad++; $display("FAIL jal_decode: got state=%0d imm=%b want state=1 imm=100", state_o, ImmSrc);
    end
    tick(1'b0);
    total++;
    if ({state_o, PCWrite} !== {4'd9, 1'b1}) begin
      bad++; $display("FAIL jal_jump: got state=%0d pcw=%b want state=9 pcw=1", state_o, PCWrite);
    end
    tick(1'b0);
    tick(1'b0);
    total++;
    if (state_o !== 4'd0) begin bad++; $display("FAIL jal_return: got %0d want 0", state_o); end
  endtask

  task automatic test_sw_wait;
    logic [3:0] st [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
    logic       rd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int rc = 0;
    op = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 6; i++) begin
      tick(rd[i]);
      rc += int'(retire);
      total++;
      if (state_o !== st[i]) begin
        bad++; $display("FAIL sw_state cyc%0d: got %0d want %0d", i, state_o, st[i]);
      end
      if (i == 2) begin
        total++;
        if ({ImmSrc, MemReq} !== 4'b001_0) begin
          bad++; $display("FAIL sw_memadr: got %b want 0010", {ImmSrc, MemReq});
        end
      end
      if (i == 3 || i == 4) begin
        total++;
        if ({MemReq, MemWrite, AdrSrc, retire} !== {3'b111, (i == 4)}) begin
          bad++; $display("FAIL sw_memwrite cyc%0d: got %b want %b", i, {MemReq, MemWrite, AdrSrc, retire}, {3'b111, (i == 4)});
        end
      end
    end
    total++;
    if (rc !== 1) begin bad++; $display("FAIL sw_retire_count: got %0d want 1", rc); end
  endtask

  task automatic test_illegal;
    op = 7'b0110011; funct3 = 3'b000;
    tick(1'b1);
    tick(1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(i[0]);
      total++;
      if ({state_o, outs} !== {4'd15, 20'd1}) begin
        bad++; $display("FAIL trap_hold cyc%0d: got state=%0d outs=%h want state=15 outs=00001", i, state_o, outs);
      end
    end
    @(negedge clk); rst_n = 1'b0; #1;
    total++;
    if ({state_o, outs} !== 24'd0) begin
      bad++; $display("FAIL trap_reset: got %h want 000000", {state_o, outs});
    end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
    total++;
    if ({state_o, illegal, MemReq} !== {4'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL trap_release: got state=%0d ill=%b req=%b want 0 0 1", state_o, illegal, MemReq);
    end
  endtask

  task automatic test_reset_mid_store;
    op = 7'b0100011; funct3 = 3'b010;
    tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
    total++;
    if ({state_o, MemReq, MemWrite} !== {4'd5, 2'b11}) begin
      bad++; $display("FAIL midrst_pre: got state=%0d req=%b wr=%b want 5 1 1", state_o, MemReq, MemWrite);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rst_n = 1'b0; mem_ready = 1'b1; #1;
      total++;
      if ({state_o, MemReq, MemWrite, PCWrite, RegWrite, retire} !== 9'd0) begin
        bad++; $display("FAIL midrst_hold cyc%0d: got %b want 0", i, {state_o, MemReq, MemWrite, PCWrite, RegWrite, retire});
      end
    end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
    total++;
    if ({state_o, MemReq, MemWrite, AdrSrc} !== {4'd0, 3'b100}) begin
      bad++; $display("FAIL midrst_release: got %b want 0000100", {state_o, MemReq, MemWrite, AdrSrc});
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_slli();
    test_lw_wait();
    test_branch();
    test_jalr();
    test_jal();
    test_sw_wait();
    test_illegal();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller for the multi-cycle RV32I core. Steps the shared datapath (unified memory port, PC/OldPC/IR, register file, ALU, ALUOut register) through fetch, decode, execute, memory and writeback states. Supports addi, slli, lw, sw, beq, bne, jal and jalr. Issues a variable-latency request/ready handshake to the unified memory.

## Interface
Parameters:
- none; all widths are fixed by the ISA subset.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- op  in  7  IR[6:0], valid from DECODE onward
- funct3  in  3  IR[14:12]
- Zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes current request at this edge
- MemReq  out  1  memory request, held until mem_ready
- MemWrite  out  1  store qualifier for MemReq
- AdrSrc  out  1  memory address: 0 PC, 1 ALUOut
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register file write of Result
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4
- ALUctrl  out  3  000 add, 001 sub, 110 sll
- ImmSrc  out  3  000 I, 001 S, 010 B, 100 J
- ResultSrc  out  2  00 ALUOut, 01 mem read data, 10 ALU result direct
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  sticky unsupported-instruction flag
- state_o  out  4  current state encoding, for debug and bench

## Operation
Unlisted outputs are 0 in every state. State encodings:
- FETCH=0
- DECODE=1
- MEMADR=2
- MEMREAD=3
- MEMWB=4
- MEMWRITE=5
- EXECI=6
- ALUWB=7
- BRANCH=8
- JAL=9
- JALR=10
- TRAP=15

Per-state outputs and transitions:
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - While mem_ready=0: stay in FETCH.
  - When mem_ready=1: assert IRWrite=1 and PCWrite=1 in that cycle (PC<=PC+4), then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add. ALUOut captures the branch/jump target.
  - ImmSrc=100 if op=1101111, else 010.
  - Next state by opcode:
    - 0000011 with funct3=010 → MEMADR
    - 0100011 with funct3=010 → MEMADR
    - 0010011 with funct3 000 or 001 → EXECI
    - 1100011 with funct3 000 or 001 → BRANCH
    - 1101111 → JAL
    - 1100111 with funct3=000 → JALR
    - anything else → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add.
  - ImmSrc=000 for loads, 001 for stores.
  - Loads go to MEMREAD; stores go to MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Then FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. When mem_ready=1: retire=1, then FETCH.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000.
  - ALUctrl=000 for funct3=000; 110 for funct3=001.
  - Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1. Then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUctrl=001, ResultSrc=00, retire=1. Then FETCH.
  - PCWrite = (funct3=000 & Zero) | (funct3=001 & ~Zero).
- JAL: PCWrite=1, ResultSrc=00 (PC<=target), ALUSrcA=01, ALUSrcB=10, add (ALUOut<=OldPC+4). Then ALUWB, which writes rd.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, add (ALUOut<=rs1+imm). Then JAL.
  - rs1 is read before rd is written, so rd=rs1 is safe.
- TRAP: illegal=1; all other outputs 0. Stays in TRAP until reset.

## Timing
- Reset: when rst_n=0 at a rising edge, the next state is FETCH and illegal clears.
  - While rst_n=0, every output is forced to 0, including MemReq; state_o reads 0.
  - The first MemReq is in the first cycle with rst_n=1.
- Reset asserted mid-instruction (including while waiting on mem_ready) abandons the instruction. No PCWrite or RegWrite occurs in reset cycles.
- Handshake: MemReq, MemWrite and AdrSrc are stable from assertion until the edge where mem_ready=1. The transfer completes at that edge.
  - mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
  - A zero-wait memory may assert mem_ready in the first MemReq cycle.
- Cycles per instruction with zero-wait memory; each wait cycle adds one:
  - addi / slli: 4
  - lw: 5
  - sw: 4
  - beq / bne: 3
  - jal: 4
  - jalr: 5
- retire is high in exactly one cycle per instruction, including a not-taken branch.
- Zero is sampled combinationally in BRANCH only.

## Test plan
- Reset with rst_n=0 for 3 cycles, then release → all outputs 0 during reset; state_o=0 and MemReq=1 in the first cycle after release.
- addi (op=0010011, funct3=000), zero-wait memory → state sequence 0,1,6,7,0; IRWrite and PCWrite in cycle 0, RegWrite in cycle 3, retire once.
- lw with mem_ready held low for 2 extra cycles in MEMREAD → MEMREAD lasts 3 cycles with MemReq=1 and AdrSrc=1 stable throughout; then MEMWB with ResultSrc=01.
- beq with Zero=1, then bne with Zero=1 → PCWrite=1 in BRANCH for beq, 0 for bne; both take 3 cycles and each asserts retire.
- jalr (op=1100111, funct3=000) → sequence 0,1,10,9,7,0; PCWrite in JAL, RegWrite in ALUWB.
- op=0110011 → state 15, illegal=1 held for 10 cycles; rst_n=0 then high → FETCH with illegal=0. Also: reset asserted mid-MEMWRITE → no further MemReq until release.
